wide_add_seq: RTL and testbench
===============================

Name: wide_add_seq

Overview:
- Multi-cycle sequencer that performs a W = N*CHUNKS bit addition on a single N-bit combinational adder slice (the ripple-carry adder).
- It accepts a wide operand pair through a valid/ready handshake and feeds the slice one N-bit chunk per cycle, LSB chunk first.
- It chains the slice carry through a register, assembles the wide sum, and presents it on a valid/ready output.
- It sits directly upstream and downstream of the adder slice in the CGRA adder datapath.

Parameters:
- N, 8, width of the attached adder slice in bits.
- CHUNKS, 4, number of N-bit chunks per operation; W = N*CHUNKS. Legal values are CHUNKS >= 2.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  wide operand pair is valid.
- in_ready  output  1  sequencer can accept an operand pair.
- in_a  input  W  wide operand A.
- in_b  input  W  wide operand B.
- in_c  input  1  wide carry-in.
- out_valid  output  1  wide result is valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  W  wide sum.
- out_c  output  1  wide carry-out.
- add_a  output  N  chunk of A driven to the slice.
- add_b  output  N  chunk of B driven to the slice.
- add_c_in  output  1  carry driven to the slice.
- add_sum  input  N  sum returned by the slice (combinational, same cycle).
- add_c_out  input  1  carry-out returned by the slice.

Behaviour:
- Reset:
  - state=IDLE; idx=0; carry_reg=0; a_reg=0; b_reg=0.
  - out_valid=0; out_sum=0; out_c=0.
  - in_ready=0 in any cycle where rst=1.
  - Reset has priority over every other event, including a handshake in the same cycle.
- States:
  - IDLE
  - RUN
  - DONE
- in_ready: equals (state==IDLE) or (state==DONE and out_ready), gated low by rst.
- IDLE:
  - add_a, add_b and add_c_in are all 0.
  - On in_valid&&in_ready: latch in_a->a_reg, in_b->b_reg, in_c->carry_reg; idx<=0; go to RUN.
- RUN:
  - Drive add_a=a_reg[idx*N +: N], add_b=b_reg[idx*N +: N], add_c_in=carry_reg.
  - Each edge: out_sum[idx*N +: N]<=add_sum; carry_reg<=add_c_out; idx<=idx+1.
  - When idx==CHUNKS-1: out_c<=add_c_out, out_valid<=1, go to DONE, idx<=0.
  - in_valid is ignored; in_ready=0.
- DONE:
  - add_* are 0; out_sum, out_c and out_valid are held stable until out_valid&&out_ready.
  - On out_ready with no accepted input: out_valid<=0; go to IDLE.
  - On out_ready with in_valid (back-to-back): the result retires and the new operands are latched on the same edge; out_valid<=0; go to RUN.
- Latency:
  - Input handshake at edge t0 means out_valid=1 after edge t0+CHUNKS.
  - Peak throughput is one operation per CHUNKS+1 cycles.
- Width rules:
  - idx width is clog2(CHUNKS), minimum 1.
  - The sum is modulo 2^W; out_c is the true carry out of bit W-1.
- Partial sum: out_sum chunks being overwritten during RUN are don't-care while out_valid=0. The bench must not check out_sum unless out_valid=1.
- Reset mid-RUN: the operation is discarded and no out_valid is produced. The next accepted operation computes correctly with no stale carry.
- in_a, in_b and in_c may change freely after acceptance; only the latched copies are used.

Test Plan (N=8, CHUNKS=4, W=32):
- Carry across a chunk: in_a=0x000000FF, in_b=0x00000001, in_c=0, handshake at t0 -> out_valid after edge t0+4, out_sum=0x00000100, out_c=0. Also check add_c_in=1 during chunk 1.
- Full ripple: in_a=0xFFFFFFFF, in_b=0x00000000, in_c=1 -> out_sum=0x00000000, out_c=1. Also check add_c_in=1 in all chunks 1..3.
- Backpressure: out_ready=0 for 3 cycles after out_valid, with in_valid held high -> out_sum and out_c stable and in_ready=0 throughout; retire on the 4th cycle, then IDLE.
- Back-to-back: in DONE with out_ready=1 and in_valid=1 (0x12345678+0x9ABCDEF0, c=0) -> accepted on the same edge; the next out_valid comes 4 edges later with out_sum=0xACF13568, out_c=0.
- Reset mid-RUN: assert rst for 1 cycle at idx=2 -> next cycle state IDLE, out_valid=0, add_*=0. A subsequent 0x80000000+0x80000000 gives out_sum=0, out_c=1.
- Random regression: 1000 random in_a/in_b/in_c with random out_ready stalls -> every result matches the 33-bit reference sum; no result is lost or duplicated.

Source files
------------

// File: rtl/wide_add_seq.sv
// Multi-cycle W-bit adder that time-multiplexes one N-bit ripple-carry slice,
// feeding it LSB chunk first and chaining the slice carry through a register.
module wide_add_seq #(
   parameter  int N      = 8,
   parameter  int CHUNKS = 4,
   localparam int W      = N * CHUNKS
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_a,
   input  logic [W-1:0] in_b,
   input  logic         in_c,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_sum,
   output logic         out_c,
   output logic [N-1:0] add_a,
   output logic [N-1:0] add_b,
   output logic         add_c_in,
   input  logic [N-1:0] add_sum,
   input  logic         add_c_out
);

   localparam int IW = (CHUNKS > 2) ? $clog2(CHUNKS) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(CHUNKS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t         state_q, state_d;
   logic [IW-1:0]  idx_q, idx_d;
   logic           carry_q, carry_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   logic [W-1:0]   sum_q, sum_d;
   logic           oc_q, oc_d;
   logic           ov_q, ov_d;
   logic           ready_s;

   // Next-state, slice drive and handshake readiness
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      carry_d  = carry_q;
      a_d      = a_q;
      b_d      = b_q;
      sum_d    = sum_q;
      oc_d     = oc_q;
      ov_d     = ov_q;
      ready_s  = 1'b0;
      add_a    = {N{1'b0}};
      add_b    = {N{1'b0}};
      add_c_in = 1'b0;
      case (state_q)
         S_IDLE: begin
            ready_s = 1'b1;
            if (in_valid) begin
               a_d     = in_a;
               b_d     = in_b;
               carry_d = in_c;
               idx_d   = {IW{1'b0}};
               state_d = S_RUN;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_RUN: begin
            add_a    = a_q[idx_q*N +: N];
            add_b    = b_q[idx_q*N +: N];
            add_c_in = carry_q;
            sum_d[idx_q*N +: N] = add_sum;
            carry_d  = add_c_out;
            if (idx_q == LAST_IDX) begin
               oc_d    = add_c_out;
               ov_d    = 1'b1;
               idx_d   = {IW{1'b0}};
               state_d = S_DONE;
            end else begin
               idx_d   = idx_q + IW'(1);
            end
         end
         S_DONE: begin
            ready_s = out_ready;
            if (out_ready) begin
               ov_d = 1'b0;
               // Back-to-back: retire and accept on the same edge
               if (in_valid) begin
                  a_d     = in_a;
                  b_d     = in_b;
                  carry_d = in_c;
                  idx_d   = {IW{1'b0}};
                  state_d = S_RUN;
               end else begin
                  state_d = S_IDLE;
               end
            end else begin
               state_d = S_DONE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         idx_q   <= {IW{1'b0}};
         carry_q <= 1'b0;
         a_q     <= {W{1'b0}};
         b_q     <= {W{1'b0}};
         sum_q   <= {W{1'b0}};
         oc_q    <= 1'b0;
         ov_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         oc_q    <= oc_d;
         ov_q    <= ov_d;
      end
   end

   assign in_ready  = ready_s & ~rst;
   assign out_valid = ov_q;
   assign out_sum   = sum_q;
   assign out_c     = oc_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Directed and random self-checking bench for wide_add_seq; the bench models
// the attached N-bit adder slice combinationally.
module tb_wide_add_seq;
   localparam int N = 8;
   localparam int CHUNKS = 4;
   localparam int W = N * CHUNKS;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         in_c = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b0;
   logic [W-1:0] out_sum;
   logic         out_c;
   logic [N-1:0] add_a;
   logic [N-1:0] add_b;
   logic         add_c_in;
   logic [N-1:0] add_sum;
   logic         add_c_out;
   logic [N:0]   slice_s;

   int total = 0;
   int bad = 0;

   wide_add_seq #(.N(N), .CHUNKS(CHUNKS)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_c(in_c),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_c(out_c),
      .add_a(add_a), .add_b(add_b), .add_c_in(add_c_in),
      .add_sum(add_sum), .add_c_out(add_c_out)
   );

   always #5 clk = ~clk;

   // Reference ripple-carry slice
   always_comb begin
      slice_s   = {1'b0, add_a} + {1'b0, add_b} + {{N{1'b0}}, add_c_in};
      add_sum   = slice_s[N-1:0];
      add_c_out = slice_s[N];
   end

   // Offer an operand pair until accepted; returns just after the accept edge
   task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      bit ok;
      ok = 1'b0;
      in_a = a; in_b = b; in_c = c; in_valid = 1'b1;
      for (int i = 0; i < 20 && !ok; i++) begin
         #1;
         if (in_ready) ok = 1'b1;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      total++;
      if (!ok) begin bad++; $display("FAIL accept_timeout: got no in_ready, required in_ready=1"); end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_valid = 1'b1; in_a = 32'hFFFF_FFFF; in_b = 32'h0000_0001; out_ready = 1'b1;
      @(posedge clk); #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid: got %b required 0", out_valid); end
      total++; if ({out_c, out_sum} !== 33'd0) begin bad++; $display("FAIL rst_out_sum: got %h required 0", {out_c, out_sum}); end
      total++; if (add_a !== 8'h00) begin bad++; $display("FAIL rst_add_a: got %h required 00", add_a); end
      @(posedge clk); #1;
      in_valid = 1'b0; rst = 1'b0; out_ready = 1'b0;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b required 1", in_ready); end
      total++; if (add_a !== 8'h00) begin bad++; $display("FAIL rst_no_accept: got add_a=%h required 00", add_a); end
   endtask

   task automatic test_carry_chunk();
      start_op(32'h0000_00FF, 32'h0000_0001, 1'b0);
      total++; if (add_a !== 8'hFF || add_c_in !== 1'b0) begin bad++; $display("FAIL carry_chunk0: got a=%h cin=%b required a=ff cin=0", add_a, add_c_in); end
      @(posedge clk); #1;
      total++; if (add_c_in !== 1'b1) begin bad++; $display("FAIL carry_chunk1_cin: got %b required 1", add_c_in); end
      @(posedge clk); #1;
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL carry_early_valid: got %b required 0", out_valid); end
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL carry_latency: got out_valid=%b required 1", out_valid); end
      total++; if (out_sum !== 32'h0000_0100 || out_c !== 1'b0) begin bad++; $display("FAIL carry_sum: got %b_%h required 0_00000100", out_c, out_sum); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL carry_retire: got valid=%b ready=%b required 0/1", out_valid, in_ready); end
   endtask

   task automatic test_ripple_backpressure();
      start_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
      total++; if (add_c_in !== 1'b1) begin bad++; $display("FAIL ripple_cin0: got %b required 1", add_c_in); end
      for (int k = 1; k < CHUNKS; k++) begin
         @(posedge clk); #1;
         total++; if (add_c_in !== 1'b1) begin bad++; $display("FAIL ripple_cin%0d: got %b required 1", k, add_c_in); end
      end
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || out_sum !== 32'h0000_0000 || out_c !== 1'b1) begin bad++; $display("FAIL ripple_sum: got v=%b %b_%h required v=1 1_00000000", out_valid, out_c, out_sum); end
      in_valid = 1'b1; in_a = 32'h1111_1111; in_b = 32'h2222_2222; in_c = 1'b0;
      for (int k = 0; k < 3; k++) begin
         #1;
         total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready%0d: got %b required 0", k, in_ready); end
         total++; if (out_valid !== 1'b1 || out_sum !== 32'h0000_0000 || out_c !== 1'b1) begin bad++; $display("FAIL stall_hold%0d: got v=%b %b_%h required v=1 1_00000000", k, out_valid, out_c, out_sum); end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || add_a !== 8'h00) begin bad++; $display("FAIL stall_retire: got v=%b rdy=%b a=%h required 0/1/00", out_valid, in_ready, add_a); end
   endtask

   task automatic test_back_to_back();
      start_op(32'h0000_0001, 32'h0000_0002, 1'b0);
      repeat (CHUNKS) begin @(posedge clk); #1; end
      total++; if (out_valid !== 1'b1 || out_sum !== 32'h0000_0003) begin bad++; $display("FAIL b2b_first: got v=%b %h required v=1 00000003", out_valid, out_sum); end
      in_valid = 1'b1; in_a = 32'h1234_5678; in_b = 32'h9ABC_DEF0; in_c = 1'b0; out_ready = 1'b1;
      #1;
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL b2b_ready: got %b required 1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0; in_a = 32'h0; in_b = 32'h0;
      total++; if (out_valid !== 1'b0 || add_a !== 8'h78 || add_b !== 8'hF0) begin bad++; $display("FAIL b2b_accept: got v=%b a=%h b=%h required 0/78/f0", out_valid, add_a, add_b); end
      for (int k = 1; k < CHUNKS; k++) begin
         @(posedge clk); #1;
         total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_early%0d: got %b required 0", k, out_valid); end
      end
      @(posedge clk); #1;
      total++; if (out_valid !== 1'b1 || out_sum !== 32'hACF1_3568 || out_c !== 1'b0) begin bad++; $display("FAIL b2b_sum: got v=%b %b_%h required v=1 0_acf13568", out_valid, out_c, out_sum); end
      @(posedge clk); #1;
      out_ready = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_retire: got %b required 0", out_valid); end
   endtask

   task automatic test_reset_mid_run();
      bit seen;
      start_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      total++; if (add_c_in !== 1'b1) begin bad++; $display("FAIL midrst_cin2: got %b required 1", add_c_in); end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      total++; if (out_valid !== 1'b0 || add_a !== 8'h00 || add_b !== 8'h00 || add_c_in !== 1'b0 || in_ready !== 1'b1) begin
         bad++; $display("FAIL midrst_idle: got v=%b a=%h b=%h cin=%b rdy=%b required 0/00/00/0/1", out_valid, add_a, add_b, add_c_in, in_ready);
      end
      seen = 1'b0;
      repeat (6) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
      total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_no_result: got out_valid=1 required 0"); end
      start_op(32'h8000_0000, 32'h8000_0000, 1'b0);
      total++; if (add_c_in !== 1'b0) begin bad++; $display("FAIL midrst_stale_carry: got %b required 0", add_c_in); end
      repeat (CHUNKS) begin @(posedge clk); #1; end
      total++; if (out_valid !== 1'b1 || out_sum !== 32'h0000_0000 || out_c !== 1'b1) begin bad++; $display("FAIL midrst_sum: got v=%b %b_%h required v=1 1_00000000", out_valid, out_c, out_sum); end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_random();
      logic [W:0] exp_q[$];
      logic [W:0] e;
      int sent, rcvd;
      sent = 0; rcvd = 0;
      for (int cyc = 0; cyc < 20000 && rcvd < 1000; cyc++) begin
         in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
         in_a      = $urandom;
         in_b      = $urandom;
         in_c      = 1'($urandom_range(0, 1));
         out_ready = ($urandom_range(0, 3) != 0);
         #1;
         if (out_valid && out_ready) begin
            total++;
            if (exp_q.size() == 0) begin
               bad++; $display("FAIL rand_dup: got result %b_%h required none pending", out_c, out_sum);
            end else begin
               e = exp_q.pop_front();
               if ({out_c, out_sum} !== e) begin bad++; $display("FAIL rand_sum%0d: got %h required %h", rcvd, {out_c, out_sum}, e); end
            end
            rcvd++;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back({1'b0, in_a} + {1'b0, in_b} + {{W{1'b0}}, in_c});
            sent++;
         end
         @(posedge clk); #1;
      end
      in_valid = 1'b0; out_ready = 1'b0;
      total++;
      if (sent != 1000 || rcvd != 1000 || exp_q.size() != 0) begin
         bad++; $display("FAIL rand_count: got sent=%0d rcvd=%0d pending=%0d required 1000/1000/0", sent, rcvd, exp_q.size());
      end
   endtask

   initial begin
      @(posedge clk); #1;
      test_reset();
      test_carry_chunk();
      test_ripple_backpressure();
      test_back_to_back();
      test_reset_mid_run();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
